// File: rtl/ram_bist_ctrl.sv
// March-style BIST controller for dual_port_ram: writes a pattern to every
// location through port 0, reads it back through port 1 and compares, then
// repeats the whole sequence with the complemented pattern.
module ram_bist_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  wr_en,
  output logic                  port_en_0,
  output logic [ADDR_WIDTH-1:0] addr_in_0,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  port_en_1,
  output logic [ADDR_WIDTH-1:0] addr_in_1,
  input  logic [DATA_WIDTH-1:0] data_out_1,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CHECK, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH+1:0] ERR_MAX = '1;

  state_t                state_q, state_d;
  logic                  inv_q, inv_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  chk_valid_q, chk_valid_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [ADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;
  logic [ADDR_WIDTH+1:0] err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic                  port_en_0_q, port_en_0_d;
  logic [ADDR_WIDTH-1:0] addr_in_0_q, addr_in_0_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  port_en_1_q, port_en_1_d;
  logic [ADDR_WIDTH-1:0] addr_in_1_q, addr_in_1_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  mismatch;

  // Test pattern: (addr+1) truncated to the data width, optionally inverted.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic flip);
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a) + DATA_WIDTH'(1);
    return flip ? ~p : p;
  endfunction

  // Next-state, compare pipeline and output decode.
  always_comb begin
    state_d     = state_q;
    inv_d       = inv_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;

    // Read data lags the issued read by one cycle, so the expected value and
    // address are staged here and compared when the RAM data arrives.
    chk_valid_d = (state_q == S_READ);
    exp_d       = pattern(cnt_q, inv_q);
    chk_addr_d  = cnt_q;

    mismatch = chk_valid_q && (data_out_1 != exp_q);
    if (mismatch) begin
      if (err_count_q != ERR_MAX) err_count_d = err_count_q + 1'b1;
      if (err_count_q == '0)      fail_addr_d = chk_addr_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WRITE;
          inv_d       = 1'b0;
          cnt_d       = '0;
          err_count_d = '0;
          fail_addr_d = '0;
        end
      end
      S_WRITE: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (!inv_q) begin
          inv_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered RAM-side
    // signals present each access in the cycle the FSM enters it.
    wr_en_d     = (state_d == S_WRITE);
    port_en_0_d = (state_d == S_WRITE);
    addr_in_0_d = (state_d == S_WRITE) ? cnt_d : '0;
    data_in_d   = (state_d == S_WRITE) ? pattern(cnt_d, inv_d) : '0;
    port_en_1_d = (state_d == S_READ);
    addr_in_1_d = (state_d == S_READ) ? cnt_d : '0;
    busy_d      = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_CHECK);
    done_d      = (state_d == S_DONE);
    pass_d      = (state_d == S_DONE) && (err_count_d == '0);
  end

  // State and registered outputs; reset aborts any test in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      inv_q       <= 1'b0;
      cnt_q       <= '0;
      chk_valid_q <= 1'b0;
      exp_q       <= '0;
      chk_addr_q  <= '0;
      err_count_q <= '0;
      fail_addr_q <= '0;
      wr_en_q     <= 1'b0;
      port_en_0_q <= 1'b0;
      addr_in_0_q <= '0;
      data_in_q   <= '0;
      port_en_1_q <= 1'b0;
      addr_in_1_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inv_q       <= inv_d;
      cnt_q       <= cnt_d;
      chk_valid_q <= chk_valid_d;
      exp_q       <= exp_d;
      chk_addr_q  <= chk_addr_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
      wr_en_q     <= wr_en_d;
      port_en_0_q <= port_en_0_d;
      addr_in_0_q <= addr_in_0_d;
      data_in_q   <= data_in_d;
      port_en_1_q <= port_en_1_d;
      addr_in_1_q <= addr_in_1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign port_en_0 = port_en_0_q;
  assign addr_in_0 = addr_in_0_q;
  assign data_in   = data_in_q;
  assign port_en_1 = port_en_1_q;
  assign addr_in_1 = addr_in_1_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_addr = fail_addr_q;

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Built-in self-test controller for the `dual_port_ram` block. It is the hardware initiator that drives the RAM's write port (port 0) and read port (port 1). On `start` it runs two march passes:

- Pass 0 writes the true pattern to every location, then reads it back and compares.
- Pass 1 does the same with the complemented pattern.

It reports the pass/fail result, the first failing address and a mismatch count. It sits between system control logic and one `dual_port_ram` instance, and only drives the RAM while `busy` is high.

## Interface
- `ADDR_WIDTH`, default 4: RAM address width.
- `DATA_WIDTH`, default 8: RAM data width.
- `DEPTH`, default 16: number of locations tested, addresses 0..DEPTH-1. Requires DEPTH ≤ 2^ADDR_WIDTH and DEPTH ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request to begin a test; sampled only when not busy.
- `wr_en`  out  1: RAM write enable.
- `port_en_0`  out  1: RAM port 0 enable.
- `addr_in_0`  out  ADDR_WIDTH: RAM write address.
- `data_in`  out  DATA_WIDTH: RAM write data.
- `port_en_1`  out  1: RAM port 1 enable.
- `addr_in_1`  out  ADDR_WIDTH: RAM read address.
- `data_out_1`  in  DATA_WIDTH: RAM read data, valid one cycle after the address/enable are registered.
- `busy`  out  1: test in progress.
- `done`  out  1: test finished; held until the next accepted `start` or reset.
- `pass`  out  1: `done` and zero mismatches.
- `err_count`  out  ADDR_WIDTH+2: number of mismatches, saturating at all-ones.
- `fail_addr`  out  ADDR_WIDTH: address of the first mismatch; 0 if none.

## Operation
- FSM states: IDLE, WRITE, READ, CHECK, DONE.
- Pass bit `inv` selects the data pattern:
  - inv=0: data = (addr+1) truncated to DATA_WIDTH.
  - inv=1: data = bitwise NOT of (addr+1).
- IDLE/DONE + `start`:
  - clear `err_count`, `fail_addr`, `done`, `pass`;
  - set inv=0 and address counter=0;
  - go to WRITE.
- WRITE, one location per cycle:
  - `wr_en`=`port_en_0`=1, `addr_in_0`=cnt, `data_in`=pattern(cnt);
  - at cnt=DEPTH-1, reset cnt to 0 and go to READ.
- READ, one read per cycle:
  - `port_en_1`=1, `addr_in_1`=cnt;
  - register expected=pattern(cnt), the address and a `chk_valid` flag for the compare next cycle;
  - at cnt=DEPTH-1, go to CHECK.
- Compare, whenever `chk_valid` is set (during READ and in CHECK):
  - a mismatch occurs when `data_out_1` ≠ the registered expected value;
  - on mismatch, increment `err_count` (saturating);
  - if this is the first mismatch, capture the registered address into `fail_addr`.
- CHECK performs the compare for the final read only. Then:
  - if inv=0, set inv=1, cnt=0 and go to WRITE;
  - otherwise go to DONE.
- DONE: `done`=1, `pass`=(`err_count`==0), `busy`=0. The result is held.
- `start` while `busy` is ignored.
- Write and read phases never overlap, so there are no same-address collisions.
- Outside the active phase, the port enables and `wr_en` are 0. Addresses and data are don't-care but are driven to 0.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state=IDLE, inv=0, cnt=0;
  - all outputs 0: `wr_en`, `port_en_0`, `port_en_1`, `addr_in_0`, `addr_in_1`, `data_in`, `busy`, `done`, `pass`, `err_count`, `fail_addr`.
- Reset mid-test aborts immediately. No RAM access occurs after reset assertion.
- All RAM-side outputs are registered.
- `start` is accepted at edge T0. First write is presented in cycle T0+1.
- `busy` is high from T0+1 until the DONE transition.
- Per pass: DEPTH write cycles + DEPTH read cycles + 1 CHECK cycle.
- `done` rises 2·(2·DEPTH+1) cycles after T0 (66 for DEPTH=16). `busy` falls in the same cycle.
- Read latency is fixed at 1 cycle: the read issued in cycle k is compared in cycle k+1.
- Counter wrap: cnt never exceeds DEPTH-1. When DEPTH < 2^ADDR_WIDTH, the upper addresses are untouched.
- `start` in DONE restarts the test in the same manner as from IDLE.

## Test plan
- Fault-free RAM model, `start` pulse:
  - write port shows addr0→0x01 … addr15→0x10, then addr0→0xFE … addr15→0xEF;
  - `done`=1 at T0+66, `pass`=1, `err_count`=0, `fail_addr`=0.
- RAM model with addr 5 bit 0 stuck-at-0:
  - pass 0 is clean (0x06);
  - pass 1 reads 0xF8 against expected 0xF9;
  - result: `err_count`=1, `fail_addr`=5, `pass`=0, `done`=1.
- RAM model returning 0x00 for all reads:
  - result: `err_count`=32, `fail_addr`=0, `pass`=0.
- `rst_n` pulsed low during the pass-1 READ phase:
  - all outputs go to 0 asynchronously and the FSM is in IDLE;
  - a subsequent `start` yields a full clean 66-cycle run with `pass`=1.
- `start` asserted repeatedly during `busy`:
  - no effect; `done` still occurs at T0+66.
- `start` in DONE after a failing run, with a fault-free model:
  - `done`/`err_count` clear at acceptance;
  - new result is `pass`=1.
